demux_rr_dispatcher: RTL and testbench

//  Upstream feeder for the 1-to-4 DEMUX: accepts a valid/ready input stream and holds one beat in a register.
//  For each beat it selects a destination channel (round-robin or fixed), then drives dout/sel/out_valid into the DEMUX.

---
 rtl/demux_pkg.sv | 19 +
 rtl/demux_rr_dispatcher_rr_pick.sv | 30 +++
 rtl/demux_rr_dispatcher.sv | 130 +++++++++++++
 tb/tb_demux_rr_dispatcher.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared types and constants for the DEMUX feeder and its round-robin picker.
package demux_pkg;

    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } disp_state_t;

    typedef logic [SEL_W-1:0] ch_sel_t;

    // Next channel index, wrapping 3 -> 0 through the natural width of ch_sel_t.
    function automatic ch_sel_t ch_inc(input ch_sel_t ch);
        return ch_sel_t'(ch + ch_sel_t'(1));
    endfunction

endpackage

// File: rtl/demux_rr_dispatcher_rr_pick.sv
// Rotate-priority picker: the first requesting channel at or above ptr wins,
// scanning upward and wrapping past the top channel. With no request the
// pointer itself is returned and any is low.
module rr_pick
    import demux_pkg::*;
(
    input  logic [N_CH-1:0] req,
    input  ch_sel_t         ptr,
    output ch_sel_t         pick,
    output logic            any
);

    ch_sel_t idx;

    // Scan from the farthest offset back toward ptr so the nearest request is the last written.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before any branch; otherwise paths that skip an assignment infer a latch.
        pick = ptr;
        any  = 1'b0;
        idx  = ptr;
        for (int k = N_CH - 1; k >= 0; k--) begin
            idx = ptr + ch_sel_t'(k);
            if (req[idx]) begin
                pick = idx;
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_rr_dispatcher.sv
// One-beat holding stage in front of a 1-to-4 DEMUX. Each accepted beat gets
// a destination channel (fixed or round-robin over ready sinks) that is frozen
// until the beat is delivered; delivered beats are counted per channel.
module demux_rr_dispatcher
    import demux_pkg::*;
#(
    parameter int DATA_W  = 1,
    parameter int COUNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    in_ready,
    input  logic                    mode_fixed,
    input  logic [SEL_W-1:0]        fixed_sel,
    input  logic [N_CH-1:0]         ch_ready,
    output logic                    out_valid,
    output logic [SEL_W-1:0]        sel,
    output logic [DATA_W-1:0]       dout,
    output logic [N_CH*COUNT_W-1:0] beat_cnt
);

    disp_state_t        state;
    disp_state_t        state_nxt;
    ch_sel_t            sel_q;
    ch_sel_t            rr_ptr;
    ch_sel_t            rr_choice;
    ch_sel_t            pick_sel;
    logic               rr_any;
    logic [DATA_W-1:0]  dout_q;
    logic [COUNT_W-1:0] cnt_q [N_CH];
    logic               out_fire;
    logic               in_fire;

    // Handshakes: a new beat may enter when the slot is empty or emptying this cycle.
    assign out_fire = out_valid & ch_ready[sel_q];
    assign in_ready = rst_n & (~out_valid | out_fire);
    assign in_fire  = in_valid & in_ready;

    rr_pick u_rr_pick (
        .req  (ch_ready),
        .ptr  (rr_ptr),
        .pick (rr_choice),
        .any  (rr_any)
    );

    // Destination for a beat accepted this cycle; with nothing ready round-robin falls back to rr_ptr.
    always_comb begin
        pick_sel = rr_ptr;
        if (mode_fixed) begin
            pick_sel = fixed_sel;
        end else if (rr_any) begin
            pick_sel = rr_choice;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values regardless of block order.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: HOLD persists while a beat is held or being replaced back-to-back.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_fire) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_fire && !in_fire) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: the held beat is presented straight from the holding register.
    always_comb begin
        out_valid = (state == HOLD);
        sel       = sel_q;
        dout      = dout_q;
    end

    // Holding register: loads only on in_fire, so sel/dout stay frozen while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q  <= '0;
            dout_q <= '0;
        end else if (in_fire) begin
            sel_q  <= pick_sel;
            dout_q <= in_data;
        end
    end

    // Round-robin pointer advances past the chosen channel only for round-robin beats.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (in_fire && !mode_fixed) begin
            rr_ptr <= ch_inc(pick_sel);
        end
    end

    // Per-channel delivered-beat counters, indexed by the outgoing (old) sel; wrap silently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: this array is small debug state that must read zero after reset, so every entry is cleared explicitly; large storage arrays are normally left unreset.
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (out_fire) begin
            cnt_q[sel_q] <= cnt_q[sel_q] + COUNT_W'(1);
        end
    end

    // Flatten the counter array onto the stats bus, channel i at [i*COUNT_W +: COUNT_W].
    for (genvar g = 0; g < N_CH; g++) begin : g_cnt_out
        assign beat_cnt[g*COUNT_W +: COUNT_W] = cnt_q[g];
    end

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Bench for demux_rr_dispatcher: two instances (8-bit and 2-bit counters) share
// stimulus; a scoreboard queue holds the expected held beat and is compared
// whenever the model says the beat is delivered.
module tb_demux_rr_dispatcher;

    localparam int DW = 4;

    typedef struct {
        logic [1:0]    sel;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          mode_fixed;
    logic [1:0]    fixed_sel;
    logic [3:0]    ch_ready;

    logic          in_ready,  in_ready_w;
    logic          out_valid, out_valid_w;
    logic [1:0]    sel,       sel_w;
    logic [DW-1:0] dout,      dout_w;
    logic [31:0]   beat_cnt;
    logic [7:0]    beat_cnt_w;

    int total = 0;
    int bad   = 0;

    beat_t      sb[$];
    logic [1:0] rr_m;
    int         cnt_m [4];
    logic       model_on = 1'b0;
    logic       exp_ov, exp_of, exp_ir;

    always #5 clk = ~clk;

    demux_rr_dispatcher #(.DATA_W(DW), .COUNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mode_fixed(mode_fixed), .fixed_sel(fixed_sel),
        .ch_ready(ch_ready), .out_valid(out_valid), .sel(sel), .dout(dout),
        .beat_cnt(beat_cnt)
    );

    demux_rr_dispatcher #(.DATA_W(DW), .COUNT_W(2)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_w), .mode_fixed(mode_fixed), .fixed_sel(fixed_sel),
        .ch_ready(ch_ready), .out_valid(out_valid_w), .sel(sel_w), .dout(dout_w),
        .beat_cnt(beat_cnt_w)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_pick(input logic [3:0] rdy, input logic [1:0] ptr);
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (int'(ptr) + k) % 4;
            if (rdy[idx]) return 2'(idx);
        end
        return ptr;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string tag, input int c0, input int c1, input int c2, input int c3);
        int c [4];
        c = '{c0, c1, c2, c3};
        for (int i = 0; i < 4; i++) begin
            check({tag, "_cnt8"}, 32'(beat_cnt[i*8 +: 8]), 32'(c[i] % 256));
            check({tag, "_cnt2"}, 32'(beat_cnt_w[i*2 +: 2]), 32'(c[i] % 4));
        end
    endtask

    // Scoreboard and handshake model, evaluated mid-cycle when inputs and outputs are stable.
    always @(negedge clk) begin
        exp_ov = (sb.size() != 0);
        exp_of = exp_ov && ch_ready[sb[0].sel];
        exp_ir = rst_n && (!exp_ov || exp_of);
        if (model_on) begin
            check("out_valid", 32'(out_valid), 32'(exp_ov));
            check("out_valid_w", 32'(out_valid_w), 32'(exp_ov));
            check("in_ready", 32'(in_ready), 32'(exp_ir));
            check("in_ready_w", 32'(in_ready_w), 32'(exp_ir));
            if (exp_ov) begin
                check("sel", 32'(sel), 32'(sb[0].sel));
                check("dout", 32'(dout), 32'(sb[0].data));
                check("sel_w", 32'(sel_w), 32'(sb[0].sel));
            end
            for (int i = 0; i < 4; i++) begin
                check("cnt8", 32'(beat_cnt[i*8 +: 8]), 32'(cnt_m[i] % 256));
                check("cnt2", 32'(beat_cnt_w[i*2 +: 2]), 32'(cnt_m[i] % 4));
            end
        end
        if (!rst_n) begin
            sb.delete();
            rr_m = 2'd0;
            for (int i = 0; i < 4; i++) cnt_m[i] = 0;
            model_on = 1'b1;
        end else if (model_on) begin
            if (exp_of) begin
                beat_t e;
                e = sb.pop_front();
                cnt_m[e.sel]++;
            end
            if (in_valid && exp_ir) begin
                beat_t n;
                if (mode_fixed) begin
                    n.sel = fixed_sel;
                end else begin
                    n.sel = model_pick(ch_ready, rr_m);
                    rr_m  = n.sel + 2'd1;
                end
                n.data = in_data;
                sb.push_back(n);
            end
        end
    end

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b1;
        in_data    = 4'h5;
        mode_fixed = 1'b0;
        fixed_sel  = 2'd0;
        ch_ready   = 4'hF;

        // 1. Reset with in_valid asserted.
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check_counts("rst", 0, 0, 0, 0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        step();

        // 2. Round-robin stream with every sink ready.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 4'(i + 1);
            #1;
            check("rr_in_ready", 32'(in_ready), 32'd1);
            step();
            check("rr_sel", 32'(sel), 32'(i % 4));
        end
        in_valid = 1'b0;
        step();
        check_counts("rr", 2, 2, 2, 2);

        // 3. Round-robin skipping unready channels.
        do_reset(1);
        ch_ready = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 4'(8 + i);
            step();
            check("skip_sel", 32'(sel), (i % 2 == 0) ? 32'd1 : 32'd3);
        end
        in_valid = 1'b0;
        step();
        check_counts("skip", 0, 2, 0, 2);

        // 4. Backpressure on a fixed channel; new input and fixed_sel changes are ignored while held.
        do_reset(1);
        mode_fixed = 1'b1;
        fixed_sel  = 2'd2;
        ch_ready   = 4'b0000;
        in_valid   = 1'b1;
        in_data    = 4'hA;
        step();
        in_data   = 4'hB;
        fixed_sel = 2'd3;
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_sel", 32'(sel), 32'd2);
            check("bp_dout", 32'(dout), 32'hA);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            step();
        end
        ch_ready = 4'b0100;
        in_valid = 1'b0;
        #1;
        check("bp_drain_ready", 32'(in_ready), 32'd1);
        step();
        check("bp_drained", 32'(out_valid), 32'd0);
        check_counts("bp", 0, 0, 1, 0);

        // 5. Counter wrap: five beats to fixed channel 1.
        do_reset(1);
        fixed_sel = 2'd1;
        ch_ready  = 4'hF;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 4'(i);
            step();
        end
        in_valid = 1'b0;
        step();
        check_counts("wrap", 0, 5, 0, 0);

        // 6. Reset while a beat is held, after rr_ptr has moved.
        mode_fixed = 1'b0;
        in_valid   = 1'b1;
        in_data    = 4'h3;
        step();
        ch_ready = 4'b0000;
        in_data  = 4'h4;
        step();
        in_valid = 1'b0;
        check("mid_held", 32'(out_valid), 32'd1);
        do_reset(1);
        check("mid_out_valid", 32'(out_valid), 32'd0);
        check_counts("mid", 0, 0, 0, 0);
        ch_ready = 4'hF;
        in_valid = 1'b1;
        in_data  = 4'h7;
        step();
        check("mid_rr_ptr0", 32'(sel), 32'd0);
        in_valid = 1'b0;
        step();

        // Randomised traffic, including occasional resets.
        for (int i = 0; i < 400; i++) begin
            rst_n      = ($urandom_range(0, 63) != 0);
            in_valid   = ($urandom_range(0, 3) != 0);
            in_data    = 4'($urandom);
            ch_ready   = 4'($urandom);
            mode_fixed = ($urandom_range(0, 3) == 0);
            fixed_sel  = 2'($urandom);
            step();
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        ch_ready = 4'hF;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
